// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the divider-controller slice: op codes, FSM states
// and the divider handshake constants.
package div_ctrl_pkg;

   localparam int DIV_XLEN    = 32;
   localparam int DIV_RADDR_W = 5;

   localparam logic [1:0] DIV_OP_DIV  = 2'b00;
   localparam logic [1:0] DIV_OP_DIVU = 2'b01;
   localparam logic [1:0] DIV_OP_REM  = 2'b10;
   localparam logic [1:0] DIV_OP_REMU = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_BUSY  = 3'd1,
      ST_CORR  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_ABORT = 3'd4
   } div_state_e;

   localparam logic                DivStart       = 1'b1;
   localparam logic                DivResultReady = 1'b1;
   localparam logic [DIV_XLEN-1:0] ZeroWord       = '0;

   function automatic logic op_is_rem(input logic [1:0] op);
      return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
   endfunction

   function automatic logic op_is_unsigned(input logic [1:0] op);
      return (op == DIV_OP_DIVU) || (op == DIV_OP_REMU);
   endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Start/operand/result handshake between the controller and the shared
// signed multi-cycle divider.
interface div_ctrl_if #(parameter int XLEN = 32);
   logic              div_start;
   logic [XLEN-1:0]   div_dividend;
   logic [XLEN-1:0]   div_divisor;
   logic              div_ready;
   logic [2*XLEN-1:0] div_result;

   modport master (
      output div_start, div_dividend, div_divisor,
      input  div_ready, div_result
   );

   modport slave (
      input  div_start, div_dividend, div_divisor,
      output div_ready, div_result
   );
endinterface

// File: rtl/div_special_case.sv
// Combinational classifier for divide requests the divider cannot or need not
// handle. DIV_FASTPATH_EN adds divisor==1 and dividend==0 as local cases.
module div_special_case
   import div_ctrl_pkg::*;
#(
   parameter int XLEN = DIV_XLEN
) (
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            local_hit,
   output logic [XLEN-1:0] local_q,
   output logic [XLEN-1:0] local_r,
   output logic            usplit
);

   localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

   logic uns;
   logic uge;

   assign uns = op_is_unsigned(op);
   assign uge = rs1 >= rs2;

   always_comb begin
      local_hit = 1'b0;
      local_q   = '0;
      local_r   = '0;
      usplit    = 1'b0;
      if (rs2 == '0) begin
         local_hit = 1'b1;
         local_q   = '1;
         local_r   = rs1;
      end else if (!uns && rs1 == MinInt && rs2 == '1) begin
         local_hit = 1'b1;
         local_q   = MinInt;
      end else if (uns && rs2[XLEN-1]) begin
         // divisor >= 2^(XLEN-1): unsigned quotient can only be 0 or 1
         local_hit = 1'b1;
         local_q   = {{(XLEN-1){1'b0}}, uge};
         local_r   = uge ? rs1 - rs2 : rs1;
`ifdef DIV_FASTPATH_EN
      end else if (rs2 == XLEN'(1)) begin
         local_hit = 1'b1;
         local_q   = rs1;
      end else if (rs1 == '0) begin
         local_hit = 1'b1;
`endif
      end else if (uns && rs1[XLEN-1]) begin
         usplit = 1'b1;
      end
   end

endmodule

// File: rtl/div_ctrl.sv
// Execute-stage initiator for the multi-cycle signed divider: resolves special
// cases locally, corrects unsigned results, stalls while busy. See DIV_FASTPATH_EN.
module div_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int XLEN    = DIV_XLEN,
   parameter int RADDR_W = DIV_RADDR_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_i,
   input  logic [1:0]         op_i,
   input  logic [XLEN-1:0]    rs1_i,
   input  logic [XLEN-1:0]    rs2_i,
   input  logic [RADDR_W-1:0] rd_i,
   input  logic               flush_i,
   output logic               stall_o,
   output logic               wb_valid_o,
   output logic [XLEN-1:0]    wb_data_o,
   output logic [RADDR_W-1:0] wb_rd_o,
   div_ctrl_if.master         div
);

   // Only rs1[0] is needed after issue; the rest already sits in the dividend register.
   typedef struct packed {
      logic [1:0]         op;
      logic [RADDR_W-1:0] rd;
      logic               rs1_lsb;
      logic [XLEN-1:0]    rs2;
      logic               usplit;
   } req_t;

   div_state_e         state, state_n;
   req_t               req_q, req_n;
   logic               start_q, start_n;
   logic [XLEN-1:0]    dvd_q, dvd_n, dvs_q, dvs_n;
   logic [XLEN-1:0]    q_q, q_n, r_q, r_n;
   logic               wb_valid_q, wb_valid_n;
   logic [XLEN-1:0]    wb_data_q, wb_data_n;
   logic [RADDR_W-1:0] wb_rd_q, wb_rd_n;
   logic               abort_q, abort_n;

   logic               loc_hit, loc_usplit;
   logic [XLEN-1:0]    loc_q, loc_r;
   logic               accept;
   logic [XLEN-1:0]    res_q, res_r;

   logic [XLEN:0]      corr_t, corr_d;
   logic               corr_ge;
   logic [XLEN-1:0]    corr_q, corr_r;

   div_special_case #(.XLEN(XLEN)) u_special (
      .op        (op_i),
      .rs1       (rs1_i),
      .rs2       (rs2_i),
      .local_hit (loc_hit),
      .local_q   (loc_q),
      .local_r   (loc_r),
      .usplit    (loc_usplit)
   );

   assign accept = (state == ST_IDLE) && req_i && !flush_i;
   assign res_q  = div.div_result[XLEN-1:0];
   assign res_r  = div.div_result[2*XLEN-1:XLEN];

   // Restore the dropped dividend LSB: one restoring-division step on {r', rs1[0]}.
   assign corr_t  = {r_q, req_q.rs1_lsb};
   assign corr_ge = corr_t >= {1'b0, req_q.rs2};
   assign corr_d  = corr_t - {1'b0, req_q.rs2};
   assign corr_q  = (q_q << 1) | {{(XLEN-1){1'b0}}, corr_ge};
   assign corr_r  = XLEN'(corr_ge ? corr_d : corr_t);

   always_comb begin
      state_n    = state;
      req_n      = req_q;
      start_n    = start_q;
      dvd_n      = dvd_q;
      dvs_n      = dvs_q;
      q_n        = q_q;
      r_n        = r_q;
      wb_valid_n = 1'b0;
      wb_data_n  = wb_data_q;
      wb_rd_n    = wb_rd_q;
      abort_n    = abort_q;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               req_n.op      = op_i;
               req_n.rd      = rd_i;
               req_n.rs1_lsb = rs1_i[0];
               req_n.rs2     = rs2_i;
               req_n.usplit  = loc_usplit;
               if (loc_hit) begin
                  wb_valid_n = 1'b1;
                  wb_data_n  = op_is_rem(op_i) ? loc_r : loc_q;
                  wb_rd_n    = rd_i;
               end else begin
                  start_n = DivStart;
                  dvd_n   = loc_usplit ? (rs1_i >> 1) : rs1_i;
                  dvs_n   = rs2_i;
                  state_n = ST_BUSY;
               end
            end
         end
         ST_BUSY: begin
            if (flush_i) begin
               start_n = 1'b0;
               abort_n = 1'b0;
               state_n = ST_ABORT;
            end else if (div.div_ready == DivResultReady) begin
               q_n     = res_q;
               r_n     = res_r;
               start_n = 1'b0;
               if (req_q.usplit) begin
                  state_n = ST_CORR;
               end else begin
                  wb_valid_n = 1'b1;
                  wb_data_n  = op_is_rem(req_q.op) ? res_r : res_q;
                  wb_rd_n    = req_q.rd;
                  state_n    = ST_DRAIN;
               end
            end
         end
         ST_CORR: begin
            if (flush_i) begin
               abort_n = 1'b0;
               state_n = ST_ABORT;
            end else begin
               q_n        = corr_q;
               r_n        = corr_r;
               wb_valid_n = 1'b1;
               wb_data_n  = op_is_rem(req_q.op) ? corr_r : corr_q;
               wb_rd_n    = req_q.rd;
               state_n    = ST_DRAIN;
            end
         end
         ST_DRAIN: state_n = ST_IDLE;
         ST_ABORT: begin
            // divider may pulse ready with junk while unwinding; ignored here
            abort_n = 1'b1;
            if (abort_q) state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         req_q      <= '0;
         start_q    <= 1'b0;
         dvd_q      <= XLEN'(ZeroWord);
         dvs_q      <= XLEN'(ZeroWord);
         q_q        <= XLEN'(ZeroWord);
         r_q        <= XLEN'(ZeroWord);
         wb_valid_q <= 1'b0;
         wb_data_q  <= XLEN'(ZeroWord);
         wb_rd_q    <= '0;
         abort_q    <= 1'b0;
      end else begin
         state      <= state_n;
         req_q      <= req_n;
         start_q    <= start_n;
         dvd_q      <= dvd_n;
         dvs_q      <= dvs_n;
         q_q        <= q_n;
         r_q        <= r_n;
         wb_valid_q <= wb_valid_n;
         wb_data_q  <= wb_data_n;
         wb_rd_q    <= wb_rd_n;
         abort_q    <= abort_n;
      end
   end

   assign stall_o          = (state == ST_BUSY) || (state == ST_CORR) || (accept && !loc_hit);
   assign wb_valid_o       = wb_valid_q;
   assign wb_data_o        = wb_data_q;
   assign wb_rd_o          = wb_rd_q;
   assign div.div_start    = start_q;
   assign div.div_dividend = dvd_q;
   assign div.div_divisor  = dvs_q;

endmodule
